fetch_decode_unit: RTL and testbench

- Fetch/decode stage directly downstream of the 8-bit program counter.
- Takes the current PC value, fetches a 16-bit instruction from instruction memory through a req/ready handshake, registers it, and decodes it.
- Returns branch/add to the PC and issues a one-cycle pc_step strobe that qualifies PC advance.
- Presents decoded fields to the execute stage with a valid/stall handshake.

---
 rtl/fetch_decode_unit_pkg.sv | 22 ++
 rtl/fetch_decode_unit_instr_decoder.sv | 34 +++
 rtl/fetch_decode_unit.sv | 125 ++++++++++++
 tb/tb_fetch_decode_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_unit_pkg.sv
// Shared constants for the fetch/decode stage: opcodes, FSM encoding, default widths.
// Imported by the top and the instruction decoder.
package fetch_decode_unit_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 16;
    localparam int TIMEOUT_DEF = 15;

    localparam logic [3:0] OP_BEQZ = 4'hC;
    localparam logic [3:0] OP_BNEZ = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_HALT   = 3'd4
    } fd_state_t;

endpackage

// File: rtl/fetch_decode_unit_instr_decoder.sv
// Splits an instruction into its fields and evaluates the branch condition.
// Purely combinational, zero latency; no handshake, consumer samples when it needs to.
module fetch_decode_unit_instr_decoder
    import fetch_decode_unit_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic [INSTR_W-1:0] instr,
    input  logic               zero_flag,
    output logic [3:0]         opcode,
    output logic [3:0]         rd,
    output logic [3:0]         rs,
    output logic [3:0]         rt,
    output logic [7:0]         imm,
    output logic               take
);

    assign opcode = instr[15:12];
    assign rd     = instr[11:8];
    assign rs     = instr[7:4];
    assign rt     = instr[3:0];
    assign imm    = instr[7:0];

    always_comb begin
        take = 1'b0;
        case (opcode)
            OP_BEQZ: take = zero_flag;
            OP_BNEZ: take = ~zero_flag;
            OP_JMP:  take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode stage: fetches the instruction at pc, decodes it, strobes pc_step on issue.
// Latency: 3 cycles + memory wait from FETCH to pc_step; ex_stall holds ISSUE indefinitely.
// Optional FETCH_TIMEOUT_EN: bounded memory wait with retry and sticky fetch_err.
module fetch_decode_unit
    import fetch_decode_unit_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [PC_W-1:0]    pc,
    input  logic               zero_flag,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    input  logic               ex_stall,
    output logic               ex_valid,
    output logic [3:0]         opcode,
    output logic [3:0]         rd,
    output logic [3:0]         rs,
    output logic [3:0]         rt,
    output logic [7:0]         imm,
    output logic               branch,
    output logic [PC_W-1:0]    add,
    output logic               pc_step,
    output logic               halted,
    output logic               fetch_err
);

    fd_state_t          state, state_nxt;
    logic [INSTR_W-1:0] instr;
    logic               dec_take;
    logic               timeout;

    fetch_decode_unit_instr_decoder #(.INSTR_W(INSTR_W)) u_dec (
        .instr     (instr),
        .zero_flag (zero_flag),
        .opcode    (opcode),
        .rd        (rd),
        .rs        (rs),
        .rt        (rt),
        .imm       (imm),
        .take      (dec_take)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TCNT_W-1:0] tcnt;
    logic              err_q;

    assign timeout   = (state == ST_WAIT) && !imem_ready && (tcnt == TCNT_W'(TIMEOUT - 1));
    assign fetch_err = err_q;

    // FETCH always precedes WAIT, so clearing here clears on every WAIT entry.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ST_FETCH)
                tcnt <= '0;
            else if (state == ST_WAIT)
                tcnt <= tcnt + TCNT_W'(1);
            if (timeout)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign fetch_err = (TIMEOUT < 0);
`endif

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        ex_valid  = 1'b0;
        pc_step   = 1'b0;
        halted    = 1'b0;
        case (state)
            ST_FETCH:  state_nxt = ST_WAIT;
            ST_WAIT: begin
                imem_req = 1'b1;
                if (imem_ready)
                    state_nxt = ST_DECODE;
                else if (timeout)
                    state_nxt = ST_FETCH;
            end
            ST_DECODE: state_nxt = (opcode == OP_HALT) ? ST_HALT : ST_ISSUE;
            ST_ISSUE: begin
                ex_valid = 1'b1;
                pc_step  = ~ex_stall;
                if (!ex_stall)
                    state_nxt = ST_FETCH;
            end
            ST_HALT:   halted = 1'b1;
            default:   state_nxt = ST_FETCH;
        endcase
    end

    // branch/add are captured once in DECODE so later zero_flag changes cannot disturb them.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= ST_FETCH;
            imem_addr <= '0;
            instr     <= '0;
            branch    <= 1'b0;
            add       <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_FETCH)
                imem_addr <= pc;
            if (state == ST_WAIT && imem_ready)
                instr <= imem_rdata;
            if (state == ST_DECODE) begin
                branch <= dec_take;
                add    <= PC_W'($signed(imm));
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: scripted fetches with a scoreboard checked on every pc_step.
module tb_fetch_decode_unit;

    logic        clk;
    logic        clr;
    logic [7:0]  pc;
    logic        zero_flag;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic        ex_stall;
    logic        ex_valid;
    logic [3:0]  opcode, rd, rs, rt;
    logic [7:0]  imm;
    logic        branch;
    logic [7:0]  add;
    logic        pc_step;
    logic        halted;
    logic        fetch_err;

    typedef struct {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [7:0] imm;
        logic       br;
        logic [7:0] add;
    } exp_t;

    exp_t sb[$];
    int   n_run      = 0;
    int   n_fail     = 0;
    int   n_steps    = 0;
    int   exp_steps  = 0;

    fetch_decode_unit dut (
        .clk        (clk),
        .clr        (clr),
        .pc         (pc),
        .zero_flag  (zero_flag),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .ex_stall   (ex_stall),
        .ex_valid   (ex_valid),
        .opcode     (opcode),
        .rd         (rd),
        .rs         (rs),
        .rt         (rt),
        .imm        (imm),
        .branch     (branch),
        .add        (add),
        .pc_step    (pc_step),
        .halted     (halted),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_br(input logic [3:0] op, input logic zf);
        if (op == 4'hC) return zf;
        if (op == 4'hD) return !zf;
        if (op == 4'hE) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_exp(input logic [15:0] iv, input logic zf);
        exp_t e;
        e.op  = iv[15:12];
        e.rd  = iv[11:8];
        e.rs  = iv[7:4];
        e.rt  = iv[3:0];
        e.imm = iv[7:0];
        e.br  = model_br(iv[15:12], zf);
        e.add = iv[7:0];
        sb.push_back(e);
        exp_steps++;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!clr && pc_step) begin
            n_steps++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("opcode", opcode, e.op);
                chk("rd", rd, e.rd);
                chk("rs", rs, e.rs);
                chk("rt", rt, e.rt);
                chk("imm", imm, e.imm);
                chk("branch", branch, e.br);
                chk("add", add, e.add);
                chk("ex_valid_step", ex_valid, 1);
            end
        end
    end

    // Precondition: DUT is in FETCH for the next rising edge. ghost drives a stray
    // imem_ready carrying HALT during the FETCH cycle, which must be ignored.
    task automatic fetch_one(input logic [7:0] pcv, input logic [15:0] iv, input logic zf,
                             input int dly, input int stall, input logic ghost);
        pc        = pcv;
        zero_flag = ~zf;
        if (ghost) begin
            imem_ready = 1'b1;
            imem_rdata = 16'hF000;
        end
        @(posedge clk); #1;
        imem_ready = 1'b0;
        chk("req_up", imem_req, 1);
        chk("imem_addr", imem_addr, pcv);
        repeat (dly) begin
            @(posedge clk); #1;
            chk("req_hold", imem_req, 1);
        end
        imem_ready = 1'b1;
        imem_rdata = iv;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        imem_rdata = 16'($urandom);
        chk("req_drop", imem_req, 0);
        chk("ex_valid_decode", ex_valid, 0);
        zero_flag = zf;
        ex_stall  = (stall > 0);
        if (iv[15:12] == 4'hF) begin
            @(posedge clk); #1;
            chk("halted", halted, 1);
            chk("halt_ex_valid", ex_valid, 0);
            return;
        end
        push_exp(iv, zf);
        @(posedge clk); #1;
        zero_flag = ~zf;
        chk("ex_valid_issue", ex_valid, 1);
        for (int i = 0; i < stall; i++) begin
            chk("stall_no_step", pc_step, 0);
            chk("stall_valid", ex_valid, 1);
            chk("stall_branch", branch, model_br(iv[15:12], zf));
            @(posedge clk); #1;
        end
        ex_stall = 1'b0;
        #1;
        chk("pc_step", pc_step, 1);
        @(posedge clk); #1;
        chk("ex_valid_drop", ex_valid, 0);
        chk("step_drop", pc_step, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int hc;
        logic [15:0] iv;
        clr        = 1'b1;
        pc         = 8'h00;
        zero_flag  = 1'b0;
        imem_rdata = 16'h0000;
        imem_ready = 1'b0;
        ex_stall   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_branch", branch, 0);
        chk("rst_pc_step", pc_step, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fetch_err", fetch_err, 0);
        chk("rst_add", add, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_rd", rd, 0);
        chk("rst_rs", rs, 0);
        chk("rst_rt", rt, 0);
        chk("rst_imm", imm, 0);
        clr = 1'b0;

        fetch_one(8'h10, 16'h1234, 1'b0, 0, 0, 1'b0);
        fetch_one(8'h11, 16'hC0FE, 1'b1, 0, 0, 1'b0);
        fetch_one(8'h12, 16'hC0FE, 1'b0, 1, 0, 1'b0);
        fetch_one(8'h13, 16'hD005, 1'b0, 2, 4, 1'b0);
        fetch_one(8'h14, 16'hD0F0, 1'b1, 0, 1, 1'b0);
        fetch_one(8'h15, 16'hE080, 1'b0, 3, 0, 1'b0);
        fetch_one(8'h16, 16'h7F7F, 1'b1, 0, 0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            iv = {4'($urandom_range(0, 14)), 12'($urandom)};
            fetch_one(8'($urandom), iv, 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 2), 1'b0);
        end

        // async clear while waiting on memory
        pc = 8'h40;
        @(posedge clk); #1;
        chk("wait_req", imem_req, 1);
        @(posedge clk); #2;
        clr = 1'b1;
        #1;
        chk("aclr_req", imem_req, 0);
        chk("aclr_addr", imem_addr, 0);
        chk("aclr_opcode", opcode, 0);
        chk("aclr_ex_valid", ex_valid, 0);
        @(posedge clk); #1;
        clr = 1'b0;
        fetch_one(8'h41, 16'h2345, 1'b0, 1, 0, 1'b1);

        fetch_one(8'h50, 16'hF000, 1'b0, 0, 0, 1'b0);
        hc = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (imem_req || pc_step) hc++;
        end
        chk("halt_quiet", hc, 0);
        chk("halt_stays", halted, 1);
        clr = 1'b1;
        #1;
        chk("halt_clr", halted, 0);
        #1;
        clr = 1'b0;
        fetch_one(8'h60, 16'h0ABC, 1'b0, 0, 0, 1'b0);

`ifdef FETCH_TIMEOUT_EN
        pc = 8'h55;
        @(posedge clk); #1;
        chk("to_req", imem_req, 1);
        repeat (14) @(posedge clk);
        #1;
        chk("to_req_15", imem_req, 1);
        chk("to_err_early", fetch_err, 0);
        @(posedge clk); #1;
        chk("to_err", fetch_err, 1);
        chk("to_req_gap", imem_req, 0);
        @(posedge clk); #1;
        chk("to_retry_req", imem_req, 1);
        chk("to_retry_addr", imem_addr, 8'h55);
        imem_ready = 1'b1;
        imem_rdata = 16'h1111;
        push_exp(16'h1111, 1'b0);
        @(posedge clk); #1;
        imem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("to_err_sticky", fetch_err, 1);
        clr = 1'b1;
        #1;
        chk("to_err_clr", fetch_err, 0);
        #1;
        clr = 1'b0;
`else
        chk("fetch_err_tied", fetch_err, 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        chk("step_count", n_steps, exp_steps);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
